// File: rtl/ro_sensor_pkg.sv
// Shared definitions for the ring-oscillator temperature sensor blocks:
// FSM state encoding and default sizing shared with the averager and controller.
package ro_sensor_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCount  = 2'd2,
        StLatch  = 2'd3
    } ro_state_e;

    // Default result width and window length
    localparam int unsigned DefWidth      = 16;
    localparam int unsigned DefGateCycles = 1000;
    localparam int unsigned DefSyncStages = 2;

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronises the asynchronous oscillator output into the clk1 domain and
// produces a one-cycle pulse on each synchronised rising edge.
module ro_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic osc_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   sync_dly_q;

    // Only the last stage is ever read; earlier stages may be metastable
    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchroniser chain and one-cycle delayed copy of its last stage
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], osc_in};
            sync_dly_q <= sync_last;
        end
    end

    // Rising edge of the synchronised oscillator
    always_comb begin
        rise = sync_last & ~sync_dly_q;
    end

endmodule

// File: rtl/ro_gate_counter.sv
// Gated frequency counter: counts synchronised oscillator rising edges over a
// fixed window of clk1 cycles and presents one saturating result per window.
module ro_gate_counter
    import ro_sensor_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned GATE_CYCLES = DefGateCycles,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      TimerW     = $clog2(GATE_CYCLES + 1);
    localparam logic [TimerW-1:0] SettleLast = TimerW'(SYNC_STAGES);
    localparam logic [TimerW-1:0] GateLast   = TimerW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  AccMax     = '1;

    ro_state_e         state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;
    logic              rise;

    // Control decoded from the current state
    logic              timer_run;
    logic              acc_run;
    logic              do_latch;

    ro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .rise   (rise)
    );

    // FSM state register
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; en=0 aborts from any active state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) state_d = StSettle;
            end
            StSettle: begin
                if (!en)                      state_d = StIdle;
                else if (timer_q == SettleLast) state_d = StCount;
            end
            StCount: begin
                if (!en)                    state_d = StIdle;
                else if (timer_q == GateLast) state_d = StLatch;
            end
            StLatch: begin
                state_d = en ? StCount : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: timer runs only while staying in SETTLE or COUNT
    always_comb begin
        busy      = (state_q != StIdle);
        timer_run = ((state_q == StSettle) && (state_d == StSettle)) ||
                    ((state_q == StCount) && (state_d == StCount));
        acc_run   = (state_q == StCount) && en;
        do_latch  = (state_q == StLatch);
    end

    // Datapath next-state: window timer, saturating accumulator, result registers
    always_comb begin
        timer_d    = timer_run ? timer_q + TimerW'(1) : '0;
        acc_d      = '0;
        sat_d      = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (acc_run) begin
            acc_d = acc_q;
            sat_d = sat_q;
            if (rise) begin
                if (acc_q == AccMax) sat_d = 1'b1;
                else                 acc_d = acc_q + WIDTH'(1);
            end
        end
        // A rise during LATCH is dropped: accumulator restarts from zero
        if (do_latch) begin
            count_d    = acc_q;
            overflow_d = sat_q;
            valid_d    = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            timer_q    <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ro_gate_counter.sv
// Directed bench for ro_gate_counter: latency, window period, saturation,
// abort on en=0, mid-window reset and stuck oscillator inputs.
module tb_ro_gate_counter;

    logic        clk1;
    logic        rst_n;
    logic        osc_in;
    logic        en_a;
    logic        en_b;
    logic [15:0] count_a;
    logic        valid_a;
    logic        overflow_a;
    logic        busy_a;
    logic [3:0]  count_b;
    logic        valid_b;
    logic        overflow_b;
    logic        busy_b;

    int unsigned osc_period;
    logic        osc_level;
    int          n_tests;
    int          n_fail;

    ro_gate_counter #(
        .WIDTH       (16),
        .GATE_CYCLES (100),
        .SYNC_STAGES (2)
    ) u_dut_a (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .osc_in      (osc_in),
        .en          (en_a),
        .count       (count_a),
        .count_valid (valid_a),
        .overflow    (overflow_a),
        .busy        (busy_a)
    );

    ro_gate_counter #(
        .WIDTH       (4),
        .GATE_CYCLES (100),
        .SYNC_STAGES (2)
    ) u_dut_b (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .osc_in      (osc_in),
        .en          (en_b),
        .count       (count_b),
        .count_valid (valid_b),
        .overflow    (overflow_b),
        .busy        (busy_b)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Oscillator model: period in clk1 cycles, 0 means held at osc_level
    initial begin
        osc_in = 1'b0;
        forever begin
            if (osc_period == 0) begin
                osc_in = osc_level;
                @(negedge clk1);
            end else begin
                osc_in = 1'b1;
                repeat (osc_period / 2) @(negedge clk1);
                osc_in = 1'b0;
                repeat (osc_period - osc_period / 2) @(negedge clk1);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts clk1 edges until the selected count_valid is seen, bounded by max
    task automatic wait_valid(input bit sel_b, input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            @(posedge clk1);
            #1;
            n++;
            if ((sel_b ? valid_b : valid_a) === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit ok;
        int seen;

        n_tests    = 0;
        n_fail     = 0;
        osc_period = 0;
        osc_level  = 1'b0;
        rst_n      = 1'b0;
        en_a       = 1'b0;
        en_b       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk1);
        #1;
        check_eq("rst_count", 32'(count_a), 0);
        check_eq("rst_valid", 32'(valid_a), 0);
        check_eq("rst_overflow", 32'(overflow_a), 0);
        check_eq("rst_busy", 32'(busy_a), 0);
        check_eq("rst_count_b", 32'(count_b), 0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Test 1: period 10, en held: first valid at edge 104, then every 101
        osc_period = 10;
        repeat (20) @(negedge clk1);
        en_a = 1'b1;
        @(posedge clk1);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t1_first_ok", 32'(ok), 1);
        check_eq("t1_latency", n, 104);
        check_eq("t1_count0", 32'(count_a), 10);
        check_eq("t1_ovf0", 32'(overflow_a), 0);
        check_eq("t1_busy", 32'(busy_a), 1);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t1_interval", n, 101);
        check_eq("t1_count1", 32'(count_a), 10);
        @(posedge clk1);
        #1;
        check_eq("t1_pulse_width", 32'(valid_a), 0);

        // Test 4: drop en at COUNT cycle 50 -> window discarded
        repeat (49) @(posedge clk1);
        @(negedge clk1);
        en_a = 1'b0;
        @(posedge clk1);
        #1;
        check_eq("t4_busy", 32'(busy_a), 0);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk1);
            #1;
            if (valid_a === 1'b1) seen++;
        end
        check_eq("t4_no_valid", seen, 0);
        check_eq("t4_count_held", 32'(count_a), 10);

        // Test 2a: oscillator stuck low
        osc_period = 0;
        osc_level  = 1'b0;
        repeat (10) @(negedge clk1);
        en_a = 1'b1;
        @(posedge clk1);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t2_low_ok", 32'(ok), 1);
        check_eq("t2_low_count0", 32'(count_a), 0);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t2_low_count1", 32'(count_a), 0);
        @(negedge clk1);
        en_a = 1'b0;

        // Test 2b: stuck high, reset clears synchroniser so SETTLE sees an edge
        osc_level = 1'b1;
        repeat (10) @(negedge clk1);
        rst_n = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        en_a  = 1'b1;
        @(posedge clk1);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t2_high_latency", n, 104);
        check_eq("t2_high_count0", 32'(count_a), 0);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t2_high_count1", 32'(count_a), 0);
        check_eq("t2_high_ovf", 32'(overflow_a), 0);

        // Test 5: one-cycle reset in mid-COUNT, then full restart
        osc_period = 10;
        wait_valid(1'b0, 300, n, ok);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t5_pre_count", 32'(count_a), 10);
        repeat (50) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b0;
        en_a  = 1'b0;
        @(posedge clk1);
        #1;
        check_eq("t5_rst_count", 32'(count_a), 0);
        check_eq("t5_rst_ovf", 32'(overflow_a), 0);
        check_eq("t5_rst_busy", 32'(busy_a), 0);
        check_eq("t5_rst_valid", 32'(valid_a), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        en_a  = 1'b1;
        @(posedge clk1);
        wait_valid(1'b0, 300, n, ok);
        check_eq("t5_restart_latency", n, 104);
        check_eq("t5_restart_count", 32'(count_a), 10);
        @(negedge clk1);
        en_a = 1'b0;

        // Test 3: WIDTH=4 saturates at 15, then recovers with slower input
        osc_period = 4;
        repeat (10) @(negedge clk1);
        en_b = 1'b1;
        @(posedge clk1);
        wait_valid(1'b1, 300, n, ok);
        check_eq("t3_sat_latency", n, 104);
        check_eq("t3_sat_count", 32'(count_b), 15);
        check_eq("t3_sat_ovf", 32'(overflow_b), 1);
        osc_period = 20;
        wait_valid(1'b1, 300, n, ok);
        wait_valid(1'b1, 300, n, ok);
        check_eq("t3_slow_ok", 32'(ok), 1);
        check_eq("t3_slow_count", 32'(count_b), 5);
        check_eq("t3_slow_ovf", 32'(overflow_b), 0);
        @(negedge clk1);
        en_b = 1'b0;
        @(posedge clk1);
        #1;
        check_eq("t3_idle_busy", 32'(busy_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
